// File: rtl/ava_pkg.sv
// Shared widths, scheduler state encoding and frame length for the ava_tx block.
package ava_pkg;

  localparam int WORK_W     = 576;
  localparam int CFG_W      = 8;
  localparam int FRAME_BITS = 928;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

endpackage

// File: rtl/ava_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module ava_cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ava_tx_sched.sv
// ava_tx_sched: one-deep work slot, config owner and frame launcher for ava_tx.
// Optional feature AVA_RESEND_EN re-launches the active work after RESEND_CYCLES idle cycles.
module ava_tx_sched
  import ava_pkg::*;
#(
  parameter int          GAP_CYCLES    = 64,
  parameter logic [31:0] RESEND_CYCLES = 32'd32000000,
  parameter int          BUSY_TIMEOUT  = 4,
  parameter logic [7:0]  PLL0_RST      = 8'h00,
  parameter logic [7:0]  PLL1_RST      = 8'h00,
  parameter logic [7:0]  MODE_RST      = 8'h00
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic              wr_valid,
  input  logic [WORK_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              cfg_we,
  input  logic [CFG_W-1:0]  cfg_pll0,
  input  logic [CFG_W-1:0]  cfg_pll1,
  input  logic [CFG_W-1:0]  cfg_mode,
  output logic              tx_start,
  output logic [WORK_W-1:0] tx_data,
  output logic [CFG_W-1:0]  tx_pll0,
  output logic [CFG_W-1:0]  tx_pll1,
  output logic [CFG_W-1:0]  tx_mode,
  input  logic              tx_busy,
  output logic [15:0]       frames_sent,
  output logic              err_no_busy,
  output logic              sched_idle
);

  // Busy timer is loaded one short because the first WAIT_BUSY cycle already counts.
  localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES);
  localparam logic [15:0] BTO_LD = (BUSY_TIMEOUT > 0) ? 16'(BUSY_TIMEOUT - 1) : 16'd0;

  state_t            state;
  logic              pend_valid;
  logic [WORK_W-1:0] pend_data;
  logic [CFG_W-1:0]  sh_pll0, sh_pll1, sh_mode;
  logic              accept;
  logic              gap_load, gap_done;
  logic              bto_load, bto_done;
  logic              resend_fire;

  assign wr_ready   = !pend_valid;
  assign accept     = wr_valid && !pend_valid;
  assign sched_idle = (state == IDLE) && !pend_valid;
  assign bto_load   = (state == START);
  assign gap_load   = ((state == WAIT_BUSY) && !tx_busy && bto_done) ||
                      ((state == WAIT_DONE) && !tx_busy);

  ava_cycle_timer #(.W(16)) u_gap_timer (
    .clk      (clk),
    .rst      (global_reset),
    .load     (gap_load),
    .load_val (GAP_LD),
    .en       (state == GAP),
    .done     (gap_done)
  );

  ava_cycle_timer #(.W(16)) u_busy_timer (
    .clk      (clk),
    .rst      (global_reset),
    .load     (bto_load),
    .load_val (BTO_LD),
    .en       (state == WAIT_BUSY),
    .done     (bto_done)
  );

`ifdef AVA_RESEND_EN
  localparam logic [31:0] RS_LD = (RESEND_CYCLES == 32'd0) ? 32'd0 : RESEND_CYCLES - 32'd1;

  logic act_valid;
  logic rs_arm;
  logic rs_done;

  // Idle timer only runs while the last work is parked and nothing newer waits.
  assign rs_arm      = (state == IDLE) && act_valid && !pend_valid;
  assign resend_fire = rs_arm && rs_done;

  ava_cycle_timer #(.W(32)) u_resend_timer (
    .clk      (clk),
    .rst      (global_reset),
    .load     (!rs_arm),
    .load_val (RS_LD),
    .en       (rs_arm),
    .done     (rs_done)
  );
`else
  assign resend_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_data <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      tx_pll0     <= PLL0_RST;
      tx_pll1     <= PLL1_RST;
      tx_mode     <= MODE_RST;
      sh_pll0     <= PLL0_RST;
      sh_pll1     <= PLL1_RST;
      sh_mode     <= MODE_RST;
      frames_sent <= 16'd0;
      err_no_busy <= 1'b0;
`ifdef AVA_RESEND_EN
      act_valid   <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      if (accept) begin
        pend_valid <= 1'b1;
      end
      if (cfg_we) begin
        sh_pll0 <= cfg_pll0;
        sh_pll1 <= cfg_pll1;
        sh_mode <= cfg_mode;
      end
      case (state)
        IDLE: begin
          // Config is latched only here, so an in-flight frame never sees a change.
          if (pend_valid || resend_fire) begin
            if (pend_valid) begin
              tx_data    <= pend_data;
              pend_valid <= 1'b0;
`ifdef AVA_RESEND_EN
              act_valid  <= 1'b1;
`endif
            end
            tx_pll0  <= sh_pll0;
            tx_pll1  <= sh_pll1;
            tx_mode  <= sh_mode;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (bto_done) begin
            err_no_busy <= 1'b1;
            state       <= GAP;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            frames_sent <= frames_sent + 16'd1;
            state       <= GAP;
          end
        end
        GAP: begin
          if (gap_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ava_tx_sched.sv
// Randomized bench for ava_tx_sched against a cycle-level transmitter and scheduler model.
module tb_ava_tx_sched;
  import ava_pkg::*;

  localparam int          GAP = 64;
  localparam int          BTO = 4;
  localparam logic [31:0] RSC = 32'd1000;
  localparam logic [7:0]  P0R = 8'hA1;
  localparam logic [7:0]  P1R = 8'h3C;
  localparam logic [7:0]  MDR = 8'h07;

  logic              clk = 1'b0;
  logic              global_reset;
  logic              wr_valid;
  logic [WORK_W-1:0] wr_data;
  logic              wr_ready;
  logic              cfg_we;
  logic [7:0]        cfg_pll0, cfg_pll1, cfg_mode;
  logic              tx_start;
  logic [WORK_W-1:0] tx_data;
  logic [7:0]        tx_pll0, tx_pll1, tx_mode;
  logic              tx_busy;
  logic [15:0]       frames_sent;
  logic              err_no_busy;
  logic              sched_idle;

  always #5 clk = ~clk;

  ava_tx_sched #(
    .GAP_CYCLES(GAP), .RESEND_CYCLES(RSC), .BUSY_TIMEOUT(BTO),
    .PLL0_RST(P0R), .PLL1_RST(P1R), .MODE_RST(MDR)
  ) dut (
    .clk(clk), .global_reset(global_reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .cfg_we(cfg_we), .cfg_pll0(cfg_pll0), .cfg_pll1(cfg_pll1), .cfg_mode(cfg_mode),
    .tx_start(tx_start), .tx_data(tx_data), .tx_pll0(tx_pll0), .tx_pll1(tx_pll1),
    .tx_mode(tx_mode), .tx_busy(tx_busy), .frames_sent(frames_sent),
    .err_no_busy(err_no_busy), .sched_idle(sched_idle)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [WORK_W-1:0] got, input logic [WORK_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: FIFO of accepted-but-unlaunched work, config history, transmitter.
  logic [WORK_W-1:0] q[$];
  logic [WORK_W-1:0] act_data;
  logic [7:0]        sh_m [3];
  logic [7:0]        sh_d1 [3];
  logic [7:0]        act_cfg [3];
  logic [15:0]       exp_frames;
  int cyc, busy_left, fall_cyc, chk_frames_at, exp_start, nb_start, prev_start, starts;
  bit have_fall, start_pend, never_busy, rand_cfg, rand_frame, exp_err;

  task automatic model_reset();
    q.delete();
    act_data      = '0;
    sh_m          = '{P0R, P1R, MDR};
    sh_d1         = '{P0R, P1R, MDR};
    act_cfg       = '{P0R, P1R, MDR};
    exp_frames    = 16'd0;
    have_fall     = 0;
    start_pend    = 0;
    exp_err       = 0;
    busy_left     = 0;
    exp_start     = -1;
    nb_start      = -1;
    chk_frames_at = -1;
    tx_busy       = 1'b0;
  endtask

  function automatic logic [WORK_W-1:0] rnd_work();
    logic [WORK_W-1:0] d;
    for (int i = 0; i < WORK_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    bit started;
    started = 0;
    if (rand_cfg) begin
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_pll0 = 8'($urandom);
      cfg_pll1 = 8'($urandom);
      cfg_mode = 8'($urandom);
    end
    if (global_reset) begin
      model_reset();
    end else begin
      if (wr_valid && wr_ready) begin
        q.push_back(wr_data);
        if (sched_idle) exp_start = cyc + 2;
      end
      if (cfg_we) sh_m = '{cfg_pll0, cfg_pll1, cfg_mode};
    end
    @(negedge clk);
    cyc++;
    if (cyc == prev_start + 1) chk("start_one_cycle", tx_start, 1'b0);
    if (exp_start == cyc) begin
      chk("accept_to_start", tx_start, 1'b1);
      exp_start = -1;
    end
    if (tx_start) begin
      started = 1;
`ifdef AVA_RESEND_EN
      if (q.size() == 0) chk("resend_interval", (cyc - prev_start) >= int'(RSC), 1'b1);
`else
      chk("start_has_work", q.size() > 0, 1'b1);
`endif
      if (q.size() > 0) act_data = q.pop_front();
      act_cfg = sh_d1;
      if (have_fall) chk("gap_after_busy", (cyc - fall_cyc) >= GAP, 1'b1);
      if (never_busy) nb_start = cyc;
      prev_start = cyc;
      starts++;
    end
    chk("wr_ready", wr_ready, q.size() == 0);
    chk("tx_data", tx_data, act_data);
    chk("tx_pll0", tx_pll0, act_cfg[0]);
    chk("tx_pll1", tx_pll1, act_cfg[1]);
    chk("tx_mode", tx_mode, act_cfg[2]);
    if (cyc == chk_frames_at) begin
      chk("frames_sent", frames_sent, exp_frames);
      chk("err_no_busy", err_no_busy, exp_err);
    end
    if (nb_start >= 0) begin
      if (cyc == nb_start + BTO) chk("err_before_timeout", err_no_busy, exp_err);
      if (cyc == nb_start + BTO + 1) begin
        exp_err = 1;
        chk("err_at_timeout", err_no_busy, 1'b1);
        chk("frames_on_timeout", frames_sent, exp_frames);
      end
    end
    sh_d1 = sh_m;
    // Transmitter: busy rises the cycle after it sees start, holds for the frame length.
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        tx_busy       = 1'b0;
        fall_cyc      = cyc;
        have_fall     = 1;
        exp_frames++;
        chk_frames_at = cyc + 1;
      end
    end else if (start_pend && !never_busy) begin
      tx_busy   = 1'b1;
      busy_left = rand_frame ? int'($urandom_range(1, 120)) : 100;
    end
    start_pend = started;
  endtask

  task automatic offer(input logic [WORK_W-1:0] d);
    bit ok;
    ok = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int k = 0; k < 4000; k++) begin
      if (wr_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    wr_valid = 1'b0;
    chk("offer_accepted", ok, 1'b1);
  endtask

  task automatic wait_quiet(input int bound);
    bit ok;
    ok = 0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (sched_idle && q.size() == 0 && busy_left == 0 && !start_pend) begin
        ok = 1;
        break;
      end
    end
    chk("drain_within_bound", ok, 1'b1);
  endtask

  task automatic wait_busy(input int bound);
    bit ok;
    ok = 0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (tx_busy) begin
        ok = 1;
        break;
      end
    end
    chk("busy_within_bound", ok, 1'b1);
  endtask

  task automatic wait_start(input int bound);
    bit ok;
    ok = 0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (tx_start) begin
        ok = 1;
        break;
      end
    end
    chk("start_within_bound", ok, 1'b1);
  endtask

  initial begin
    int s0;
    global_reset = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    cfg_we   = 1'b0;
    cfg_pll0 = 8'h00;
    cfg_pll1 = 8'h00;
    cfg_mode = 8'h00;
    cyc = 0;
    starts = 0;
    prev_start = -10;
    never_busy = 0;
    rand_cfg = 0;
    rand_frame = 0;
    model_reset();
    repeat (3) tick();
    global_reset = 1'b0;
    tick();
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, '0);
    chk("rst_frames", frames_sent, 16'd0);
    chk("rst_err", err_no_busy, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_pll0", tx_pll0, P0R);
    chk("rst_pll1", tx_pll1, P1R);
    chk("rst_mode", tx_mode, MDR);
    chk("rst_sched_idle", sched_idle, 1'b1);

    // Single item through an idle scheduler.
    offer(rnd_work());
    wait_quiet(2000);
    chk("frames_single", frames_sent, 16'd1);

    // Three back-to-back items: one in flight, one pending, one back-pressured.
    for (int i = 0; i < 3; i++) offer(rnd_work());
    wait_quiet(4000);
    chk("frames_three", frames_sent, 16'd4);

    // Config written mid-frame lands only on the next launch.
    offer(rnd_work());
    wait_busy(50);
    cfg_we = 1'b1;
    cfg_pll0 = 8'h5A;
    cfg_pll1 = 8'h11;
    cfg_mode = 8'h22;
    tick();
    cfg_we = 1'b0;
    repeat (3) tick();
    chk("pll0_mid_frame", tx_pll0, P0R);
    offer(rnd_work());
    wait_start(2000);
    chk("pll0_next_frame", tx_pll0, 8'h5A);
    wait_quiet(2000);

    // Random items, random frame lengths, random config writes.
    rand_cfg = 1;
    rand_frame = 1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      offer(rnd_work());
    end
    rand_cfg = 0;
    cfg_we = 1'b0;
    wait_quiet(4000);
    rand_frame = 0;
    chk("frames_random", frames_sent, exp_frames);

    // Transmitter never raises busy.
    never_busy = 1;
    offer(rnd_work());
    wait_quiet(500);
    chk("idle_after_timeout", sched_idle, 1'b1);
    chk("err_sticky", err_no_busy, 1'b1);
    never_busy = 0;
    nb_start = -1;

    // Reset during WAIT_DONE with a second item pending.
    offer(rnd_work());
    wait_busy(50);
    offer(rnd_work());
    repeat (5) tick();
    global_reset = 1'b1;
    tick();
    global_reset = 1'b0;
    chk("midrst_tx_start", tx_start, 1'b0);
    chk("midrst_tx_data", tx_data, '0);
    chk("midrst_frames", frames_sent, 16'd0);
    chk("midrst_err", err_no_busy, 1'b0);
    chk("midrst_wr_ready", wr_ready, 1'b1);
    chk("midrst_pll0", tx_pll0, P0R);
    chk("midrst_mode", tx_mode, MDR);
    chk("midrst_sched_idle", sched_idle, 1'b1);
    s0 = starts;
    repeat (200) tick();
    chk("no_start_after_reset", starts - s0, 0);

    // One item followed by silence.
    s0 = starts;
    offer(rnd_work());
`ifdef AVA_RESEND_EN
    repeat (3600) tick();
    chk("resend_repeats", (starts - s0) >= 3, 1'b1);
`else
    repeat (1500) tick();
    chk("single_launch_no_resend", starts - s0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ava_tx_sched.md
Name: ava_tx_sched

Overview:
Work scheduler and configuration owner for the ava_tx serial transmitter. Accepts 576-bit work items from the host-side receive path into a one-deep pending slot. Holds the PLL/mode configuration. Launches each frame with a single-cycle start pulse, then tracks the transmitter's busy output to completion. Enforces an inter-frame gap and, optionally, re-sends the last work on a timeout so the chips never starve.

Parameters:
GAP_CYCLES, 64, idle clk cycles enforced after busy falls before the next start (16-bit counter; 0 = no gap)
RESEND_CYCLES, 32'd32000000, idle cycles before the active work is re-sent (only with AVA_RESEND_EN)
BUSY_TIMEOUT, 4, cycles allowed after start for tx_busy to rise before flagging an error
PLL0_RST, 8'h00, reset value of the PLL0 config
PLL1_RST, 8'h00, reset value of the PLL1 config
MODE_RST, 8'h00, reset value of the mode config

Ports:
clk  in  1  system clock; the only clock
global_reset  in  1  synchronous, active-high reset
wr_valid  in  1  host offers a work item
wr_data  in  576  work item payload
wr_ready  out  1  pending slot empty; the item is accepted on wr_valid && wr_ready
cfg_we  in  1  writes the shadow configuration
cfg_pll0  in  8  shadow PLL0 value
cfg_pll1  in  8  shadow PLL1 value
cfg_mode  in  8  shadow mode value
tx_start  out  1  start pulse to the transmitter
tx_data  out  576  active work item
tx_pll0  out  8  active PLL0 value
tx_pll1  out  8  active PLL1 value
tx_mode  out  8  active mode value
tx_busy  in  1  transmitter busy
frames_sent  out  16  count of completed frames; wraps 0xFFFF -> 0
err_no_busy  out  1  sticky flag: busy failed to rise after a start
sched_idle  out  1  high when state is IDLE, nothing is pending and no frame is in flight

Behaviour:
- Reset values:
  - Outputs: tx_start=0, tx_data=0, frames_sent=0, err_no_busy=0, wr_ready=1.
  - Config: tx_pll0/1, tx_mode and the shadow config take the *_RST parameter values.
  - Internal: pend_valid=0, act_valid=0, state=IDLE, all timers=0.
- Reset mid-frame: returns to IDLE at once. The transmitter's own reset is the same global_reset.
- wr_ready = !pend_valid, registered-combinational. On acceptance, pend_data<=wr_data and pend_valid<=1.
- cfg_we: shadow<=cfg_*. Shadow is copied into tx_pll0/1/tx_mode only at IDLE->START, so config never changes mid-frame. cfg_we in the same cycle as launch: the old shadow is used, and the new value lands for the next frame.
- State machine: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
  - IDLE, pend_valid=1: tx_data<=pend_data, act_valid<=1, pend_valid<=0, config copied, go to START. wr_ready is low that cycle, so there is no simultaneous accept/drain conflict.
  - START: tx_start=1 for exactly this one cycle. Next state is WAIT_BUSY, timer cleared.
  - WAIT_BUSY:
    - tx_busy=1: go to WAIT_DONE.
    - BUSY_TIMEOUT cycles elapse without busy: set err_no_busy, go to GAP.
  - WAIT_DONE: on tx_busy=0, frames_sent++ and go to GAP.
  - GAP: counts GAP_CYCLES, then returns to IDLE. GAP_CYCLES=0 returns on the next cycle.
- Latency: accepted item with scheduler idle -> tx_start 2 cycles after the accept edge (accept, IDLE load, START).
- tx_data holds stable from START through WAIT_DONE. The transmitter samples it on start && !busy.
- A new item arriving while a frame is in flight waits in the pending slot. A third item is back-pressured with wr_ready=0.
- frames_sent increments only on frame completion, never on timeout.

Optional Feature:
Macro AVA_RESEND_EN.
- Defined:
  - In IDLE with act_valid=1 and pend_valid=0, a 32-bit idle timer counts.
  - At RESEND_CYCLES the active work is relaunched via START with the current shadow config copied.
  - The timer clears on any launch or reset.
- Undefined: timer logic is absent; only new work launches frames.

Decomposition:
- Package ava_pkg holds:
  - constants WORK_W=576 and CFG_W=8;
  - the state enum (IDLE/START/WAIT_BUSY/WAIT_DONE/GAP);
  - frame-length constant FRAME_BITS=928, for bench timing checks.
- One natural sub-module, ava_cycle_timer: loadable down-counter with a done flag, instantiated for the gap, busy-timeout and resend timers.

Test Plan:
- Single item, GAP_CYCLES=64, bench model of the transmitter asserting busy 1 cycle after start for 100 cycles -> exactly one tx_start pulse 2 cycles after accept, tx_data equal to the item, frames_sent=1, next start no earlier than 64 cycles after busy falls.
- Three back-to-back wr_valid while busy -> first launches, second is held pending, wr_ready=0 for the third until the second launches; frames_sent ends at 3 with payloads in order.
- cfg_we with pll0=8'h5A mid-frame -> tx_pll0 unchanged until the next START, then 8'h5A.
- Transmitter model never raises busy -> err_no_busy=1 at BUSY_TIMEOUT+1 after start, frames_sent unchanged, state returns to IDLE after the gap.
- global_reset asserted during WAIT_DONE -> next cycle all outputs at reset values, pending item discarded, wr_ready=1.
- AVA_RESEND_EN, RESEND_CYCLES=1000, one item then silence -> repeated tx_start with the same tx_data every gap+1000+frame cycles; frames_sent increments each time.
